// File: rtl/big_outport_fifo.sv
// big_outport_fifo: show-ahead FIFO behind a big_outport peripheral.
// Captures each strobed wide word, hands words to a slower consumer over
// valid/ready, and raises a sticky flag when a word is dropped while full.
// Optional build macro: BIG_OUTPORT_FIFO_COUNT_EN adds the o_count port that
// exposes the occupancy counter; without it the counter stays internal.

module big_outport_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_wr,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_full,
    output logic                     o_overflow,
    input  logic                     i_clr_overflow
`ifdef BIG_OUTPORT_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0]   o_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(32'd1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(32'd1);
    localparam logic [AW:0]   CNT_ZERO  = (AW+1)'(32'd0);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    // Storage and control state; mem_r carries no reset since pointers gate it.
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             overflow_r;

    logic             valid_s;
    logic             full_s;
    logic             rd_s;
    logic             wr_s;
    logic             drop_s;

    // Handshake decode: a read frees a slot, so a write to a full FIFO
    // still lands when the consumer takes the head word in the same cycle.
    always_comb begin
        valid_s = (count_r != CNT_ZERO);
        full_s  = (count_r == CNT_DEPTH);
        rd_s    = valid_s & i_ready;
        wr_s    = i_wr & (~full_s | rd_s);
        drop_s  = i_wr & full_s & ~rd_s;
    end

    // Word storage: capture the strobed word at the write pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards all buffered words.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_s, rd_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (i_clr_overflow) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Show-ahead output: head word straight from registers, zero when empty.
    always_comb begin
        o_data = {WIDTH{1'b0}};
        if (valid_s) begin
            o_data = mem_r[rd_ptr_r];
        end else begin
            o_data = {WIDTH{1'b0}};
        end
    end

    assign o_valid    = valid_s;
    assign o_full     = full_s;
    assign o_overflow = overflow_r;

`ifdef BIG_OUTPORT_FIFO_COUNT_EN
    assign o_count = count_r;
`endif

endmodule
